// File: rtl/jxli_fp8acc.sv
// Nibble-serial E4M3 accumulator: loads an operand four bits at a time, then adds it
// to the running sum with a multi-cycle unpack/align/add/normalise/pack sequence.
module jxli_fp8acc (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [3:0] data;

    assign clk    = io_in[0];
    assign reset  = io_in[1];
    assign enable = io_in[2];
    assign data   = io_in[6:3];
    assign clear  = io_in[7];

    typedef enum logic [3:0] {
        S_LOADH, S_LOADL, S_UNPACK, S_SPECIAL, S_SWAP,
        S_ALIGN, S_ADDSUB, S_NORM, S_PACK
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] acc;
    logic [7:0] b;
    logic       sa;
    logic       sb;
    logic       eff_sub;
    logic [4:0] ea;
    logic [4:0] eb;
    logic [7:0] ma;
    logic [7:0] mb;
    logic       spec;
    logic [7:0] spec_val;

    logic       a_nan;
    logic       a_inf;
    logic       b_nan;
    logic       b_inf;
    logic [4:0] exp_diff;

    assign a_nan    = (&acc[6:3]) &&  (|acc[2:0]);
    assign a_inf    = (&acc[6:3]) && !(|acc[2:0]);
    assign b_nan    = (&b[6:3])   &&  (|b[2:0]);
    assign b_inf    = (&b[6:3])   && !(|b[2:0]);
    assign exp_diff = ea - eb;
    assign io_out   = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOADH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LOADH:   if (enable && !clear) state_next = S_LOADL;
            S_LOADL:   if (enable) state_next = S_UNPACK;
            S_UNPACK:  state_next = S_SPECIAL;
            S_SPECIAL: state_next = (a_nan || b_nan || a_inf || b_inf) ? S_PACK : S_SWAP;
            S_SWAP:    state_next = S_ALIGN;
            S_ALIGN:   if (ea == eb) state_next = S_ADDSUB;
            S_ADDSUB:  state_next = S_NORM;
            S_NORM:    if (ma == 8'd0 || ma[7] || ma[6] || ea <= 5'd1) state_next = S_PACK;
            S_PACK:    state_next = S_LOADH;
            default:   state_next = S_LOADH;
        endcase
    end

    // Significand layout: [7] carry, [6] hidden, [5:3] mantissa, [2:0] guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= 8'h00;
            b        <= 8'h00;
            sa       <= 1'b0;
            sb       <= 1'b0;
            eff_sub  <= 1'b0;
            ea       <= 5'd0;
            eb       <= 5'd0;
            ma       <= 8'd0;
            mb       <= 8'd0;
            spec     <= 1'b0;
            spec_val <= 8'h00;
        end else begin
            case (state)
                S_LOADH: begin
                    if (enable) begin
                        if (clear) acc <= 8'h00;
                        else       b[7:4] <= data;
                    end
                end
                S_LOADL: begin
                    if (enable) b[3:0] <= data;
                end
                S_UNPACK: begin
                    sa   <= acc[7];
                    ea   <= {1'b0, (acc[6:3] == 4'd0) ? 4'd1 : acc[6:3]};
                    ma   <= {1'b0, |acc[6:3], acc[2:0], 3'b000};
                    sb   <= b[7];
                    eb   <= {1'b0, (b[6:3] == 4'd0) ? 4'd1 : b[6:3]};
                    mb   <= {1'b0, |b[6:3], b[2:0], 3'b000};
                    spec <= 1'b0;
                end
                S_SPECIAL: begin
                    spec <= a_nan || b_nan || a_inf || b_inf;
                    if (a_nan || b_nan)                       spec_val <= 8'h7F;
                    else if (a_inf && b_inf && acc[7] != b[7]) spec_val <= 8'h7F;
                    else if (a_inf)                            spec_val <= acc;
                    else                                       spec_val <= b;
                end
                S_SWAP: begin
                    eff_sub <= sa ^ sb;
                    if (eb > ea || (eb == ea && mb > ma)) begin
                        sa <= sb;
                        sb <= sa;
                        ea <= eb;
                        eb <= ea;
                        ma <= mb;
                        mb <= ma;
                    end
                end
                S_ALIGN: begin
                    if (exp_diff >= 5'd8) begin
                        mb <= 8'd0;
                        eb <= ea;
                    end else if (exp_diff != 5'd0) begin
                        mb <= mb >> 1;
                        eb <= eb + 5'd1;
                    end
                end
                S_ADDSUB: begin
                    ma <= eff_sub ? (ma - mb) : (ma + mb);
                end
                S_NORM: begin
                    if (ma[7]) begin
                        ma <= ma >> 1;
                        ea <= ea + 5'd1;
                    end else if (ma != 8'd0 && !ma[6] && ea > 5'd1) begin
                        ma <= ma << 1;
                        ea <= ea - 5'd1;
                    end
                end
                S_PACK: begin
                    // Exact zero keeps the sign only when both operands shared it.
                    if (spec)                acc <= spec_val;
                    else if (ma == 8'd0)     acc <= {sa & ~eff_sub, 7'd0};
                    else if (ea > 5'd14)     acc <= {sa, 7'h78};
                    else if (ma[6])          acc <= {sa, ea[3:0], ma[5:3]};
                    else                     acc <= {sa, 4'd0, ma[5:3]};
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jxli_fp8acc.sv
// Directed and randomized checks of the nibble-serial E4M3 accumulator against
// an integer-arithmetic reference of the add rules.
module tb_jxli_fp8acc;
    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic       clear  = 1'b0;
    logic [3:0] data   = 4'd0;
    logic [7:0] io_out;
    logic [7:0] model_acc = 8'h00;
    int         n_cmp  = 0;
    int         n_fail = 0;

    jxli_fp8acc dut (
        .io_in  ({clear, data, enable, reset, clk}),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (io_out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, io_out, exp);
        end
    endtask

    function automatic bit is_special(input logic [7:0] v);
        return v[6:3] == 4'hF;
    endfunction

    // Values are integers scaled so 1.0 at exponent e is 64 (hidden bit plus 3 mantissa and 3 guard bits).
    function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
        int ea, eb, ma, mb, sum, t;
        bit sa, sb, st, same;
        logic [3:0] e_out;
        logic [2:0] m_out;
        bit a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
        b_nan = (b[6:3] == 4'hF) && (b[2:0] != 3'd0);
        a_inf = (a[6:3] == 4'hF) && (a[2:0] == 3'd0);
        b_inf = (b[6:3] == 4'hF) && (b[2:0] == 3'd0);
        if (a_nan || b_nan) return 8'h7F;
        if (a_inf && b_inf && a[7] != b[7]) return 8'h7F;
        if (a_inf) return a;
        if (b_inf) return b;
        sa = a[7];
        sb = b[7];
        same = (sa == sb);
        ea = (a[6:3] == 4'd0) ? 1 : int'(a[6:3]);
        eb = (b[6:3] == 4'd0) ? 1 : int'(b[6:3]);
        ma = (((a[6:3] != 4'd0) ? 8 : 0) + int'(a[2:0])) * 8;
        mb = (((b[6:3] != 4'd0) ? 8 : 0) + int'(b[2:0])) * 8;
        if (eb > ea || (eb == ea && mb > ma)) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            st = sa; sa = sb; sb = st;
        end
        if (ea - eb >= 8) mb = 0;
        else              mb = mb >> (ea - eb);
        sum = same ? ma + mb : ma - mb;
        if (sum == 0) return same ? {sa, 7'h00} : 8'h00;
        if (sum >= 128) begin
            sum = sum / 2;
            ea  = ea + 1;
        end else begin
            while (sum < 64 && ea > 1) begin
                sum = sum * 2;
                ea  = ea - 1;
            end
        end
        if (ea > 14) return {sa, 7'h78};
        e_out = (sum >= 64) ? 4'(ea) : 4'd0;
        m_out = 3'((sum / 8) % 8);
        return {sa, e_out, m_out};
    endfunction

    task automatic clear_op();
        enable = 1'b1;
        clear  = 1'b1;
        data   = 4'($urandom);
        step();
        enable = 1'b0;
        clear  = 1'b0;
        check("clear", 8'h00);
        model_acc = 8'h00;
    endtask

    // want < 0 selects the reference model; otherwise want is the literal expected sum.
    task automatic add_op(input logic [7:0] op, input int want, input string tag);
        logic [7:0] old;
        logic [7:0] exp;
        bit         spc;
        old = model_acc;
        exp = (want >= 0) ? 8'(want) : ref_add(model_acc, op);
        spc = is_special(model_acc) || is_special(op);
        repeat ($urandom_range(0, 1)) step();
        enable = 1'b1;
        data   = op[7:4];
        step();
        enable = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        enable = 1'b1;
        data   = op[3:0];
        step();
        // Inputs while computing must be ignored.
        enable = 1'($urandom);
        clear  = 1'($urandom);
        data   = 4'($urandom);
        step();
        check({tag, "_hold"}, old);
        enable = 1'($urandom);
        clear  = 1'($urandom);
        data   = 4'($urandom);
        step();
        enable = 1'b0;
        clear  = 1'b0;
        step();
        if (spc) check({tag, "_special3"}, exp);
        repeat (17) step();
        check(tag, exp);
        model_acc = exp;
    endtask

    initial begin
        logic [7:0] op;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset", 8'h00);
        model_acc = 8'h00;

        add_op(8'h38, 'h38, "one");
        add_op(8'h38, 'h40, "two");
        add_op(8'h38, 'h44, "three");
        add_op(8'hC4, 'h00, "cancel");

        clear_op();
        add_op(8'h01, 'h01, "den1");
        add_op(8'h01, 'h02, "den2");
        clear_op();
        add_op(8'h07, 'h07, "den7");
        add_op(8'h01, 'h08, "den_roll");

        clear_op();
        add_op(8'h38, 'h38, "trunc_a");
        add_op(8'h18, 'h38, "trunc_b");
        clear_op();
        add_op(8'h77, 'h77, "ovf_a");
        add_op(8'h77, 'h78, "ovf_b");

        clear_op();
        add_op(8'h78, 'h78, "inf_a");
        add_op(8'hF8, 'h7F, "inf_nan");
        add_op(8'h38, 'h7F, "nan_sticky");
        clear_op();

        clear_op();
        add_op(8'h77, 'h77, "mid_setup");
        enable = 1'b1;
        data   = 4'h0;
        step();
        data   = 4'h8;
        step();
        enable = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid", 8'h00);
        model_acc = 8'h00;
        add_op(8'h38, 'h38, "after_reset");

        enable = 1'b1;
        data   = 4'h7;
        step();
        enable = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        check("reset_partial", 8'h00);
        model_acc = 8'h00;
        add_op(8'h40, 'h40, "after_partial");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) clear_op();
            op = 8'($urandom_range(0, 255));
            if (op[6:3] == 4'hF && $urandom_range(0, 3) != 0) op[6] = 1'b0;
            add_op(op, -1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
